seq_lshifter32: RTL and testbench
=================================

Name: seq_lshifter32

Overview:
- Iterative 32-bit logical left shifter for the ALU32 gate-level datapath.
- Complements the combinational right shifter in the same datapath.
- Shifts by up to STEP bit positions per clock under a Start/Busy/Done handshake.
- Trades latency for area: a 32-bit left shift takes ceil(n/STEP) cycles instead of using a full barrel network.

Parameters:
- STEP, 4, maximum shift applied per cycle; legal values 1, 2, 4, 8, 16, 32.
- WIDTH, 32, data width; fixed at 32, the only supported value.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Enable  in  1  global advance enable; when low, all state holds.
- Start  in  1  request; sampled only when Busy=0 and Enable=1.
- In1  in  32  operand to shift; captured at accept.
- In2  in  32  shift amount; captured at accept; values >=32 saturate to 32.
- Out  out  32  working/result register; result valid while Done=1 and held until the next accept.
- Busy  out  1  high in states SHIFT and DONE.
- Done  out  1  one-cycle pulse marking a valid Out.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE; Out=0, Busy=0, Done=0, remaining=0; Ovf=0 when the feature is enabled.
  - Reset asserted mid-operation aborts the operation immediately. No Done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Accept on an edge E0 with Start=1 and Enable=1.
  - Load Out<=In1 and remaining<=min(In2,32) (6-bit).
  - Go to SHIFT if remaining>0, else to DONE.
- SHIFT, on each edge with Enable=1:
  - k = min(remaining, STEP); Out <= Out<<k with zero fill; remaining -= k.
  - Go to DONE when the new remaining is 0.
- DONE: Done=1 for exactly one cycle, then IDLE on the next edge with Enable=1.
- Latency: Done is visible after edge E(ceil(n/STEP)) counted from E0, where n=min(In2,32). For n=0, Done is visible after E0 itself.
- Enable=0: state, Out, remaining and Done all hold. A Done pulse is stretched for as long as Enable is low.
- Start while Busy=1 is ignored, including in DONE. No queuing.
- Out shows intermediate values during SHIFT. Consumers sample Out only while Done=1.
- In1/In2 changes after accept have no effect.
- n=32: Out ends at 0 after ceil(32/STEP) shift cycles.

Optional Feature:
- Macro LSHIFT_OVF_EN.
- Defined:
  - Adds output Ovf (1 bit). Ovf clears at accept.
  - Ovf sets sticky if any 1 bit is shifted out of bit 31 during SHIFT.
  - Valid with Done; holds until the next accept; reset value 0.
- Undefined: no Ovf port and no overflow logic. All other timing is identical.

Decomposition:
- Package shifter_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - WIDTH=32 and SHAMT_W=6;
  - the saturation constant MAX_SHAMT=32.
- One sub-module, lshift_step: combinational shift of 32-bit data by 0..STEP.
  - Inputs: data and k.
  - Outputs: shifted data and a shifted-out-ones flag (the flag is used only under LSHIFT_OVF_EN).

Test Plan:
- STEP=4, In1=1, In2=2, Start pulse -> after E1 Out=32'h4, Done high for 1 cycle, Busy falls after E2.
- STEP=4, In1=32'h8000_0001, In2=31 -> Done after E8, Out=32'h8000_0000. With LSHIFT_OVF_EN, Ovf=1.
- In1=32'hDEAD_BEEF, In2=0 -> Done after E0, Out=32'hDEAD_BEEF. With LSHIFT_OVF_EN, Ovf=0.
- STEP=4, In2=40 (saturated), In1=32'hFFFF_FFFF -> Done after E8, Out=0. Start re-pulsed during Busy is ignored: exactly one Done.
- STEP=1, In1=3, In2=4, Enable low for 3 cycles during SHIFT -> Done delayed by exactly 3 cycles, Out=32'h30.
- Rst_n pulsed low mid-SHIFT -> Out=0 and Busy=0 immediately. A new Start on the following edge completes normally.

Source files
------------

// File: rtl/seq_lshifter32_pkg.sv
// Shared types and constants for the iterative 32-bit left shifter.
// Holds the FSM state type, data/shift-amount widths and the shift-amount saturation helper.
package shifter_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 6;

    localparam logic [WIDTH-1:0] MAX_SHAMT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Any request of 32 or more positions collapses to exactly 32.
    function automatic logic [SHAMT_W-1:0] sat_shamt(input logic [WIDTH-1:0] amt);
        logic [SHAMT_W-1:0] r;
        r = (amt >= MAX_SHAMT) ? MAX_SHAMT[SHAMT_W-1:0] : amt[SHAMT_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/seq_lshifter32_if.sv
// Request/result bundle of the iterative left shifter.
// The Ovf signal exists only when LSHIFT_OVF_EN is defined.
interface seq_lshifter32_if;
    import shifter_pkg::*;

    logic             Enable;
    logic             Start;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic [WIDTH-1:0] Out;
    logic             Busy;
    logic             Done;
`ifdef LSHIFT_OVF_EN
    logic             Ovf;
`endif

    modport master (
`ifdef LSHIFT_OVF_EN
        input  Ovf,
`endif
        output Enable, Start, In1, In2,
        input  Out, Busy, Done
    );

    modport slave (
`ifdef LSHIFT_OVF_EN
        output Ovf,
`endif
        input  Enable, Start, In1, In2,
        output Out, Busy, Done
    );

endinterface

// File: rtl/seq_lshifter32_lshift_step.sv
// Combinational left shift of a 32-bit word by 0..STEP positions with zero fill.
// With LSHIFT_OVF_EN defined it also flags any 1 bit pushed out past bit 31.
module lshift_step
    import shifter_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] k_i,
`ifdef LSHIFT_OVF_EN
    output logic               ovf_o,
`endif
    output logic [WIDTH-1:0]   data_o
);

    // A mux over the STEP+1 legal amounts stays much smaller than a full barrel.
    always_comb begin
        data_o = data_i;
`ifdef LSHIFT_OVF_EN
        ovf_o  = 1'b0;
`endif
        for (int i = 1; i <= STEP; i++) begin
            if (k_i == SHAMT_W'(i)) begin
                data_o = data_i << i;
`ifdef LSHIFT_OVF_EN
                ovf_o  = |(data_i >> (WIDTH - i));
`endif
            end
        end
    end

endmodule

// File: rtl/seq_lshifter32.sv
// Iterative 32-bit logical left shifter with a Start/Busy/Done handshake, STEP bits per cycle.
// Optional sticky overflow output Ovf is built when LSHIFT_OVF_EN is defined.
module seq_lshifter32
    import shifter_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    seq_lshifter32_if.slave  bus
);

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic [SHAMT_W-1:0]   k;
    logic [SHAMT_W-1:0]   shamt_sat;
    logic [WIDTH-1:0]     shifted;
`ifdef LSHIFT_OVF_EN
    logic                 ovf_q, ovf_d;
    logic                 step_ovf;
`endif

    assign k         = (rem_q > STEP_K) ? STEP_K : rem_q;
    assign shamt_sat = sat_shamt(bus.In2);

    lshift_step #(.STEP(STEP)) u_step (
        .data_i (out_q),
        .k_i    (k),
`ifdef LSHIFT_OVF_EN
        .ovf_o  (step_ovf),
`endif
        .data_o (shifted)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
`ifdef LSHIFT_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (bus.Enable) begin
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        out_d   = bus.In1;
                        rem_d   = shamt_sat;
                        state_d = (shamt_sat == '0) ? DONE : SHIFT;
`ifdef LSHIFT_OVF_EN
                        ovf_d   = 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    out_d = shifted;
                    rem_d = rem_q - k;
                    if (rem_q == k) state_d = DONE;
`ifdef LSHIFT_OVF_EN
                    ovf_d = ovf_q | step_ovf;
`endif
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            rem_q   <= '0;
`ifdef LSHIFT_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
`ifdef LSHIFT_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.Out  = out_q;
    assign bus.Busy = (state_q != IDLE);
    assign bus.Done = (state_q == DONE);
`ifdef LSHIFT_OVF_EN
    assign bus.Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_lshifter32.sv
// Directed bench for seq_lshifter32: a STEP=4 instance and a STEP=1 instance on one clock.
// Ovf checks are included when LSHIFT_OVF_EN is defined.
module tb_seq_lshifter32;

    logic Clk = 1'b0;
    logic Rst_n;

    always #5 Clk = ~Clk;

    seq_lshifter32_if if4 ();
    seq_lshifter32_if if1 ();

    seq_lshifter32 #(.STEP(4)) dut4 (.Clk(Clk), .Rst_n(Rst_n), .bus(if4));
    seq_lshifter32 #(.STEP(1)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(if1));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Accept one operation on dut4 and count edges after the accept edge until Done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int cyc);
        if4.In1   = a;
        if4.In2   = b;
        if4.Start = 1'b1;
        step();
        if4.Start = 1'b0;
        if4.In1   = 32'h1234_5678;
        if4.In2   = 32'd3;
        cyc = 0;
        while (!if4.Done && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    int cyc;
    int dones;

    initial begin
        Rst_n      = 1'b0;
        if4.Enable = 1'b1; if4.Start = 1'b0; if4.In1 = '0; if4.In2 = '0;
        if1.Enable = 1'b1; if1.Start = 1'b0; if1.In1 = '0; if1.In2 = '0;
        step();
        step();
        chk("rst_out", if4.Out, 32'h0);
        chk("rst_busy", {31'd0, if4.Busy}, 32'd0);
        chk("rst_done", {31'd0, if4.Done}, 32'd0);
        chk("rst_busy1", {31'd0, if1.Busy}, 32'd0);
`ifdef LSHIFT_OVF_EN
        chk("rst_ovf", {31'd0, if4.Ovf}, 32'd0);
`endif
        Rst_n = 1'b1;
        step();

        // 1 << 2: Done after E1, Busy falls after E2
        if4.In1 = 32'd1; if4.In2 = 32'd2; if4.Start = 1'b1;
        step();
        if4.Start = 1'b0;
        chk("t1_busy_e0", {31'd0, if4.Busy}, 32'd1);
        chk("t1_done_e0", {31'd0, if4.Done}, 32'd0);
        step();
        chk("t1_done_e1", {31'd0, if4.Done}, 32'd1);
        chk("t1_out", if4.Out, 32'h4);
`ifdef LSHIFT_OVF_EN
        chk("t1_ovf", {31'd0, if4.Ovf}, 32'd0);
`endif
        step();
        chk("t1_done_e2", {31'd0, if4.Done}, 32'd0);
        chk("t1_busy_e2", {31'd0, if4.Busy}, 32'd0);
        chk("t1_out_hold", if4.Out, 32'h4);

        // 31 positions in steps of 4: 8 shift cycles
        run_op(32'h8000_0001, 32'd31, cyc);
        chk("t2_cycles", cyc, 32'd8);
        chk("t2_out", if4.Out, 32'h8000_0000);
`ifdef LSHIFT_OVF_EN
        chk("t2_ovf", {31'd0, if4.Ovf}, 32'd1);
`endif
        step();

        // zero shift: Done right after the accept edge
        run_op(32'hDEAD_BEEF, 32'd0, cyc);
        chk("t3_cycles", cyc, 32'd0);
        chk("t3_done", {31'd0, if4.Done}, 32'd1);
        chk("t3_out", if4.Out, 32'hDEAD_BEEF);
`ifdef LSHIFT_OVF_EN
        chk("t3_ovf", {31'd0, if4.Ovf}, 32'd0);
`endif
        step();

        // saturated amount with Start held high throughout Busy
        if4.In1 = 32'hFFFF_FFFF; if4.In2 = 32'd40; if4.Start = 1'b1;
        step();
        cyc = 0;
        while (!if4.Done && cyc < 100) begin
            step();
            cyc++;
        end
        chk("t4_cycles", cyc, 32'd8);
        chk("t4_out", if4.Out, 32'h0);
`ifdef LSHIFT_OVF_EN
        chk("t4_ovf", {31'd0, if4.Ovf}, 32'd1);
`endif
        if4.Start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if4.Done) dones++;
        end
        chk("t4_extra_dones", dones, 32'd0);
        chk("t4_busy_after", {31'd0, if4.Busy}, 32'd0);

        // STEP=1, 3 << 4 with Enable low for three cycles mid-shift
        if1.In1 = 32'd3; if1.In2 = 32'd4; if1.Start = 1'b1;
        step();
        if1.Start = 1'b0;
        step();
        chk("t5_out_e1", if1.Out, 32'h6);
        if1.Enable = 1'b0;
        step(); step(); step();
        chk("t5_out_hold", if1.Out, 32'h6);
        chk("t5_busy_hold", {31'd0, if1.Busy}, 32'd1);
        if1.Enable = 1'b1;
        cyc = 0;
        while (!if1.Done && cyc < 100) begin
            step();
            cyc++;
        end
        chk("t5_cycles_after_en", cyc, 32'd3);
        chk("t5_out", if1.Out, 32'h30);
        if1.Enable = 1'b0;
        step(); step();
        chk("t5_done_stretch", {31'd0, if1.Done}, 32'd1);
        if1.Enable = 1'b1;
        step();
        chk("t5_done_end", {31'd0, if1.Done}, 32'd0);

        // asynchronous reset in the middle of a shift
        if4.In1 = 32'd5; if4.In2 = 32'd20; if4.Start = 1'b1;
        step();
        if4.Start = 1'b0;
        step();
        chk("t6_out_mid", if4.Out, 32'h50);
        Rst_n = 1'b0;
        #1;
        chk("t6_rst_out", if4.Out, 32'h0);
        chk("t6_rst_busy", {31'd0, if4.Busy}, 32'd0);
        chk("t6_rst_done", {31'd0, if4.Done}, 32'd0);
        #1;
        Rst_n = 1'b1;
        run_op(32'd1, 32'd5, cyc);
        chk("t6_cycles", cyc, 32'd2);
        chk("t6_out", if4.Out, 32'h20);
        step();
        chk("t6_idle", {31'd0, if4.Busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
